mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single external memory port between the instruction-fetch and data-access stages of the RISC-V pipeline. It generates the `imem_stall` and `dmem_stall` signals consumed by the hazards controller. It arbitrates simultaneous requests round-robin and runs a req/ack handshake toward a variable-latency memory. A timeout watchdog flags a non-responding memory so the pipeline cannot deadlock.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; must be a multiple of 8.
- `TIMEOUT`, default 255: maximum BUSY cycles without `mem_ack` before an access is aborted; 0 disables the watchdog.
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` in 1: fetch request (read only).
- `imem_addr` in ADDR_W: fetch address.
- `imem_rdata` out DATA_W: fetch read data; valid when `imem_req & ~imem_stall`.
- `imem_stall` out 1: fetch not complete this cycle.
- `dmem_req` in 1: data request.
- `dmem_we` in 1: 1 = write, 0 = read.
- `dmem_be` in DATA_W/8: byte enables for writes.
- `dmem_addr` in ADDR_W: data address.
- `dmem_wdata` in DATA_W: write data.
- `dmem_rdata` out DATA_W: data read result; valid when `dmem_req & ~dmem_stall & ~dmem_we`.
- `dmem_stall` out 1: data access not complete this cycle.
- `mem_req` out 1: memory request; held high until ack or timeout.
- `mem_we` out 1: memory write enable.
- `mem_be` out DATA_W/8: memory byte enables.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_ack` in 1: memory completion; meaningful only while `mem_req`=1.
- `mem_rdata` in DATA_W: memory read data; valid with `mem_ack`.
- `bus_err` out 1: sticky flag, set on a timeout.

## Operation
- **States.** IDLE, BUSY_I, BUSY_D.
- **IDLE.**
  - Only `imem_req`: latch `imem_addr`, drive `we`=0 and `be`=all-ones, go to BUSY_I.
  - Only `dmem_req`: latch addr/we/be/wdata, go to BUSY_D.
  - Both requesting: the winner is chosen by the `prio_d` register (1 = data wins); the loser keeps stalling.
  - Neither requesting: stay in IDLE.
- **Round-robin.** On every grant, `prio_d` is set so the other requester wins the next tie (`prio_d`=0 after a D grant, 1 after an I grant). Reset value is 1.
- **BUSY_x.**
  - `mem_req`=1 with the latched command held stable.
  - On `mem_ack`, return to IDLE.
  - If the watchdog count reaches TIMEOUT without an ack, return to IDLE and set `bus_err`.
- **Stall equations.**
  - `imem_stall = imem_req & ~(state==BUSY_I & done)`.
  - `dmem_stall = dmem_req & ~(state==BUSY_D & done)`.
  - `done = mem_ack | timeout_hit`.
  - In IDLE, any active request stalls.
- **Read data.**
  - `imem_rdata`/`dmem_rdata` = `mem_rdata` combinationally on the ack cycle.
  - On a timeout completion, read data is 0.
  - Otherwise read data is 0.
- **Requester withdrawal.** A requester dropping `req` mid-access (e.g. a flush on `jump_taken`) does not abort the memory transaction. The access completes, its data is discarded, and the dropped requester's stall reads 0.
- **Watchdog.** The counter clears on entry to BUSY and increments each BUSY cycle without ack. Width is `$clog2(TIMEOUT+1)`, saturating.
- **Ignored inputs.** `mem_ack` in IDLE is ignored.
- **`bus_err`.** Cleared only by `rst`; arbitration continues normally after an error.

## Timing
- **Reset values.** state=IDLE, `prio_d`=1, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, watchdog=0, `bus_err`=0.
- **Stall outputs in reset.** Stalls follow their equations (`=req` in IDLE).
- **Registered outputs.** All `mem_*` outputs are registered.
- **Combinational paths.** Stalls and rdata are combinational from state, `mem_ack` and `mem_rdata`.
- **Minimum latency.** Request at cycle 0 (IDLE, stall=1); `mem_req`=1 at cycle 1; an ack at cycle 1 makes stall=0 at cycle 1. An access therefore takes 2 cycles with 1 stall cycle.
- **Back-to-back.** The cycle after an ack is always IDLE, so there are at least 2 cycles per access. A requester still asserting `req` at the IDLE cycle is re-arbitrated.
- **Timeout timing.**
  - With TIMEOUT=N and no ack, `timeout_hit` asserts in BUSY cycle N: stall drops, `mem_req` falls the next cycle, and `bus_err`=1 the next cycle.
  - An ack coinciding with `timeout_hit` counts as a normal ack, and `bus_err` is not set.
- **Asynchronous reset mid-access.** `mem_req` drops immediately and the outstanding access is abandoned.

## Test plan
- **Single fetch.** `imem_req`=1 with addr 0x100, memory acks 1 cycle after `mem_req` rises with rdata 0xDEADBEEF. Required: `imem_stall` is 1 for 1 cycle, then 0 with `imem_rdata`=0xDEADBEEF; `mem_we`=0; `mem_be`=0xF.
- **Tie after reset.** Both requests in the same cycle (D: write, addr 0x200, wdata 0x11223344, be 0x3). Required: D granted first with `mem_addr`=0x200, `mem_be`=0x3, `mem_we`=1; I is granted next. Holding both requests asserted alternates grants D, I, D, I.
- **Variable latency.** Ack arrives 4 cycles after `mem_req` rises. Required: `mem_*` outputs are stable all 4 cycles; stall is 1 for 4 cycles in total and drops on the ack cycle.
- **Withdrawal.** `imem_req` drops 1 cycle into BUSY_I. Required: `mem_req` stays high until the ack, `imem_stall`=0 after the drop, and the next access starts only after the ack.
- **Timeout.** TIMEOUT=3 and no ack. Required: in BUSY cycle 3 `dmem_stall`=0 and `dmem_rdata`=0; the next cycle `mem_req`=0 and `bus_err`=1. `bus_err` stays 1 through later good accesses until `rst`.
- **Reset mid-access.** `rst` pulses while in BUSY_D. Required: `mem_req`=0 asynchronously; after release, state is IDLE and `prio_d`=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data access.
// Round-robin on ties, req/ack handshake to the memory, watchdog abort with sticky bus_err.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                imem_req,
    input  logic [ADDR_W-1:0]   imem_addr,
    output logic [DATA_W-1:0]   imem_rdata,
    output logic                imem_stall,
    input  logic                dmem_req,
    input  logic                dmem_we,
    input  logic [DATA_W/8-1:0] dmem_be,
    input  logic [ADDR_W-1:0]   dmem_addr,
    input  logic [DATA_W-1:0]   dmem_wdata,
    output logic [DATA_W-1:0]   dmem_rdata,
    output logic                dmem_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_err
);

    localparam int BE_W = DATA_W / 8;
    localparam bit WD_EN = (TIMEOUT > 0);
    localparam int WD_W = WD_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX  = WD_EN ? WD_W'(TIMEOUT) : '0;
    localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;      // 1: data side wins the next tie
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              bus_err_q, bus_err_d;

    logic busy;
    logic timeout_hit;
    logic done;
    logic i_done;
    logic d_done;

    assign busy        = (state_q != IDLE);
    assign timeout_hit = WD_EN && busy && (wdog_q == WD_LAST);
    assign done        = busy && (mem_ack || timeout_hit);
    assign i_done      = (state_q == BUSY_I) && done;
    assign d_done      = (state_q == BUSY_D) && done;

    assign imem_stall = imem_req && !i_done;
    assign dmem_stall = dmem_req && !d_done;
    // A watchdog abort completes the access but returns no data.
    assign imem_rdata = (i_done && mem_ack) ? mem_rdata : '0;
    assign dmem_rdata = (d_done && mem_ack) ? mem_rdata : '0;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wdog_q      <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wdog_q      <= wdog_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wdog_d      = wdog_q;
        bus_err_d   = bus_err_q;
        unique case (state_q)
            IDLE: begin
                if (dmem_req && (!imem_req || prio_q)) begin
                    state_d     = BUSY_D;
                    prio_d      = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dmem_we;
                    mem_be_d    = dmem_be;
                    mem_addr_d  = dmem_addr;
                    mem_wdata_d = dmem_wdata;
                    wdog_d      = '0;
                end else if (imem_req) begin
                    state_d    = BUSY_I;
                    prio_d     = 1'b1;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_be_d   = '1;
                    mem_addr_d = imem_addr;
                    wdog_d     = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    // An ack landing on the watchdog's last cycle is still a good access.
                    if (!mem_ack) begin
                        bus_err_d = 1'b1;
                    end
                end else if (wdog_q != WD_MAX) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

endmodule
